// File: rtl/divider_module_2_if.sv
// Start/done handshake and operand/result bus of the iterative divider.
interface divider_module_2_if #(
  parameter int WIDTH = 8
);
  logic             start_sig;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done_sig;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] reminder;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start_sig, signed_mode, dividend, divisor,
    input  busy, done_sig, quotient, reminder, div_zero, overflow
  );

  modport slave (
    input  start_sig, signed_mode, dividend, divisor,
    output busy, done_sig, quotient, reminder, div_zero, overflow
  );
endinterface

// File: rtl/divider_module_2.sv
// Restoring signed/unsigned divider, one quotient bit per clock; WIDTH+2 edges accept-to-done.
// No backpressure: start is taken only in IDLE and ignored while busy.
module divider_module_2 #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  divider_module_2_if.slave div_if
);
  typedef enum logic [1:0] {IDLE, PREP, ITER, FINISH} state_t;

  localparam int                CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, mag_q, mag_d, q_sr_q, q_sr_d;
  logic [WIDTH-1:0] quot_q, quot_d, rmd_q, rmd_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [WIDTH+1:0] shift_rem, trial;

  // One extra bit on top so the sign of trial tells whether the subtract fits.
  assign shift_rem = {rem_q, q_sr_q[WIDTH-1]};
  assign trial     = shift_rem - {2'b00, mag_q};

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    mag_d   = mag_q;
    q_sr_d  = q_sr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (div_if.start_sig) begin
          dvd_d   = div_if.dividend;
          dvs_d   = div_if.divisor;
          sgn_d   = div_if.signed_mode;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        q_neg_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
        r_neg_d = sgn_q & dvd_q[WIDTH-1];
        q_sr_d  = (sgn_q & dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
        mag_d   = (sgn_q & dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        q_sr_d = {q_sr_q[WIDTH-2:0], ~trial[WIDTH+1]};
        rem_d  = trial[WIDTH+1] ? shift_rem[WIDTH:0] : trial[WIDTH:0];
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = FINISH;
      end
      FINISH: begin
        if (dvs_q == '0) begin
          quot_d = '1;
          rmd_d  = dvd_q;
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
        end else if (sgn_q && dvd_q == MIN_NEG && dvs_q == '1) begin
          quot_d = MIN_NEG;
          rmd_d  = '0;
          dz_d   = 1'b0;
          ovf_d  = 1'b1;
        end else begin
          quot_d = q_neg_q ? -q_sr_q : q_sr_q;
          rmd_d  = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          dz_d   = 1'b0;
          ovf_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      mag_q   <= '0;
      q_sr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      mag_q   <= mag_d;
      q_sr_q  <= q_sr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign div_if.busy     = busy_q;
  assign div_if.done_sig = done_q;
  assign div_if.quotient = quot_q;
  assign div_if.reminder = rmd_q;
  assign div_if.div_zero = dz_q;
  assign div_if.overflow = ovf_q;
endmodule

// File: tb/tb_divider_module_2.sv
// Bench for divider_module_2: directed and random divisions at WIDTH=8 and WIDTH=16.
module tb_divider_module_2;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  divider_module_2_if #(.WIDTH(8))  if8 ();
  divider_module_2_if #(.WIDTH(16)) if16 ();

  divider_module_2 #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .div_if(if8));
  divider_module_2 #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .div_if(if16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: truncating division on sign-interpreted integers.
  function automatic void model(input int w, input bit sm, input longint a_in, input longint b_in,
                                output longint q, output longint r, output bit dz, output bit ov);
    longint mask, half, a, b, sa, sb;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    a = a_in & mask;
    b = b_in & mask;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q = mask; r = a; dz = 1'b1;
    end else if (sm) begin
      sa = (a >= half) ? a - (mask + 1) : a;
      sb = (b >= half) ? b - (mask + 1) : b;
      if (sa == -half && sb == -1) begin
        q = half; r = 0; ov = 1'b1;
      end else begin
        q = (sa / sb) & mask;
        r = (sa % sb) & mask;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called #1 after a rising edge with the 8-bit DUT idle.
  task automatic op8(input bit sm, input logic [7:0] a, input logic [7:0] b, input string tag);
    longint mq, mr;
    bit mdz, mov;
    logic [7:0] prev_q;
    int lat;
    model(8, sm, longint'(a), longint'(b), mq, mr, mdz, mov);
    prev_q = if8.quotient;
    if8.start_sig = 1'b1; if8.signed_mode = sm; if8.dividend = a; if8.divisor = b;
    @(posedge clk); #1;
    if8.start_sig = 1'b0; if8.dividend = ~a; if8.divisor = ~b; if8.signed_mode = ~sm;
    chk({tag, "_busy"}, if8.busy, 1);
    chk({tag, "_held"}, if8.quotient, prev_q);
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
    end while (!if8.done_sig && lat < 40);
    chk({tag, "_lat"}, lat, 10);
    chk({tag, "_q"}, if8.quotient, mq);
    chk({tag, "_r"}, if8.reminder, mr);
    chk({tag, "_dz"}, if8.div_zero, mdz);
    chk({tag, "_ov"}, if8.overflow, mov);
    chk({tag, "_busy_done"}, if8.busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, if8.done_sig, 0);
    chk({tag, "_q_keep"}, if8.quotient, mq);
  endtask

  initial begin
    longint mq, mr;
    bit mdz, mov, sm, pre_busy, seen;
    logic [7:0] a, b;
    longint qq[$], rq[$];
    bit dzq[$], ovq[$];
    int last_done, lat;

    rst_n = 1'b0;
    if8.start_sig = 0;  if8.signed_mode = 0;  if8.dividend = 0;  if8.divisor = 0;
    if16.start_sig = 0; if16.signed_mode = 0; if16.dividend = 0; if16.divisor = 0;
    #12;
    chk("rst_busy", if8.busy, 0);
    chk("rst_done", if8.done_sig, 0);
    chk("rst_q", if8.quotient, 0);
    chk("rst_r", if8.reminder, 0);
    chk("rst_dz", if8.div_zero, 0);
    chk("rst_ov", if8.overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    op8(1, 8'd9,   8'd6,   "s_9_6");
    op8(1, 8'd9,   8'hFA,  "s_9_m6");
    op8(1, 8'hF7,  8'd6,   "s_m9_6");
    op8(1, 8'hF7,  8'hFA,  "s_m9_m6");
    op8(0, 8'd200, 8'd7,   "u_200_7");
    op8(0, 8'hFF,  8'd1,   "u_255_1");
    op8(1, 8'h80,  8'hFF,  "s_ovf");
    op8(1, 8'h80,  8'd1,   "s_m128_1");
    op8(1, 8'd77,  8'd0,   "s_dz");
    op8(1, 8'd5,   8'd2,   "s_5_2");

    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom);
      b = (i % 5 == 2) ? 8'd0 : 8'($urandom);
      op8(1'($urandom), a, b, $sformatf("rand%0d", i));
    end

    // start held high, operands changing every cycle
    last_done = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a = 8'($urandom);
      b = (cyc % 7 == 3) ? 8'd0 : 8'($urandom);
      sm = 1'($urandom);
      if8.start_sig = 1'b1; if8.signed_mode = sm; if8.dividend = a; if8.divisor = b;
      pre_busy = if8.busy;
      @(posedge clk);
      if (!pre_busy) begin
        model(8, sm, longint'(a), longint'(b), mq, mr, mdz, mov);
        qq.push_back(mq); rq.push_back(mr); dzq.push_back(mdz); ovq.push_back(mov);
      end
      #1;
      if (if8.done_sig) begin
        if (qq.size() == 0) chk("b2b_spurious_done", 1, 0);
        else begin
          chk($sformatf("b2b_q_%0d", cyc), if8.quotient, qq.pop_front());
          chk($sformatf("b2b_r_%0d", cyc), if8.reminder, rq.pop_front());
          chk($sformatf("b2b_dz_%0d", cyc), if8.div_zero, dzq.pop_front());
          chk($sformatf("b2b_ov_%0d", cyc), if8.overflow, ovq.pop_front());
        end
        if (last_done >= 0) chk("b2b_gap", cyc - last_done, 11);
        last_done = cyc;
      end else begin
        chk($sformatf("b2b_busy_%0d", cyc), if8.busy, 1);
      end
    end
    if8.start_sig = 1'b0;
    lat = 0;
    while (qq.size() != 0 && lat < 20) begin
      @(posedge clk); lat++; #1;
      if (if8.done_sig) begin
        chk("drain_q", if8.quotient, qq.pop_front());
        chk("drain_r", if8.reminder, rq.pop_front());
        chk("drain_dz", if8.div_zero, dzq.pop_front());
        chk("drain_ov", if8.overflow, ovq.pop_front());
      end
    end
    chk("drain_empty", qq.size(), 0);
    @(posedge clk); #1;

    // reset during ITER step 4
    op8(0, 8'd200, 8'd7, "pre_rst");
    if8.start_sig = 1'b1; if8.signed_mode = 1'b0; if8.dividend = 8'd100; if8.divisor = 8'd3;
    @(posedge clk); #1;
    if8.start_sig = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", if8.busy, 0);
    chk("arst_done", if8.done_sig, 0);
    chk("arst_q", if8.quotient, 0);
    chk("arst_r", if8.reminder, 0);
    chk("arst_dz", if8.div_zero, 0);
    chk("arst_ov", if8.overflow, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (if8.done_sig || if8.busy) seen = 1'b1;
    end
    chk("arst_no_done", seen, 0);
    op8(0, 8'd100, 8'd3, "post_rst");

    // WIDTH=16 signed
    model(16, 1'b1, longint'(16'h8AD0), 7, mq, mr, mdz, mov);
    if16.start_sig = 1'b1; if16.signed_mode = 1'b1; if16.dividend = 16'h8AD0; if16.divisor = 16'd7;
    @(posedge clk); #1;
    if16.start_sig = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
    end while (!if16.done_sig && lat < 60);
    chk("w16_lat", lat, 18);
    chk("w16_q", if16.quotient, mq);
    chk("w16_r", if16.reminder, mr);
    chk("w16_q_const", if16.quotient, 16'hEF43);
    chk("w16_r_const", if16.reminder, 16'hFFFB);
    chk("w16_flags", {if16.div_zero, if16.overflow}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
